// File: rtl/pkt_fifo_reader.sv
// Pops a synchronous packet FIFO, frames words with sop/eop from the header length field,
// and presents them on a valid/ready stream. Optional PKT_LEN_CHECK_EN: flag/truncate over-long packets.
//
// state   | meaning
// ST_HDR  | next word landing from the FIFO is a packet header
// ST_BODY | next word landing is payload; r_rem payload words still to come
module pkt_fifo_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int LEN_WIDTH   = 9,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  len_err
);

    typedef enum logic {ST_HDR, ST_BODY} state_t;

    localparam int EW = DATA_WIDTH + 2;

    if (LEN_WIDTH > DATA_WIDTH || MAX_PKT_LEN < 1) begin : g_param_check
        $error("pkt_fifo_reader: illegal LEN_WIDTH/MAX_PKT_LEN");
    end

    logic                 r_run;
    state_t               r_state;
    logic [LEN_WIDTH-1:0] r_rem;
    logic [1:0]           r_occ;
    logic                 r_infl;
    logic                 r_len_err;
    logic [EW-1:0]        r_buf0;
    logic [EW-1:0]        r_buf1;
    logic [EW-1:0]        r_buf2;

    logic [LEN_WIDTH-1:0] w_n;
    logic [LEN_WIDTH-1:0] w_len;
    logic                 w_over;
    logic                 w_sop;
    logic                 w_eop;
    logic [EW-1:0]        w_word;
    logic [2:0]           w_fill;
    logic                 w_pop;
    logic                 w_deq;
    logic [1:0]           w_wr_idx;

    assign w_n = fifo_rd_data[LEN_WIDTH-1:0];

`ifdef PKT_LEN_CHECK_EN
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);
    assign w_over = (32'(w_n) > MAX_PKT_LEN);
    assign w_len  = w_over ? MAX_LEN : w_n;
`else
    assign w_over = 1'b0;
    assign w_len  = w_n;
`endif

    // r_run holds the pop request off until the first edge after reset release.
    assign w_fill     = {1'b0, r_occ} + {2'b0, r_infl};
    assign w_pop      = r_run & ~fifo_empty & (w_fill < 3'd3);
    assign fifo_rd_en = w_pop;

    assign w_deq    = (r_occ != 2'd0) & out_ready;
    assign w_wr_idx = r_occ - {1'b0, w_deq};

    // Tags are resolved as the popped word lands, since the length is only visible then.
    always_comb begin
        w_sop = 1'b0;
        w_eop = 1'b0;
        if (r_state == ST_HDR) begin
            w_sop = 1'b1;
            w_eop = (w_len == '0);
        end else begin
            w_eop = (r_rem <= LEN_WIDTH'(1));
        end
    end

    assign w_word = {fifo_rd_data, w_sop, w_eop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_state   <= ST_HDR;
            r_rem     <= '0;
            r_occ     <= 2'd0;
            r_infl    <= 1'b0;
            r_len_err <= 1'b0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_buf2    <= '0;
        end else begin
            r_run     <= 1'b1;
            r_infl    <= w_pop;
            r_occ     <= r_occ + {1'b0, r_infl} - {1'b0, w_deq};
            r_len_err <= r_infl & (r_state == ST_HDR) & w_over;

            if (r_infl) begin
                if (r_state == ST_HDR) begin
                    r_rem <= w_len;
                    if (w_len != '0)
                        r_state <= ST_BODY;
                end else begin
                    if (r_rem != '0)
                        r_rem <= r_rem - LEN_WIDTH'(1);
                    if (r_rem <= LEN_WIDTH'(1))
                        r_state <= ST_HDR;
                end
            end

            // Entry 0 is the head; a landing word goes to the first slot free after any dequeue.
            if (r_infl && w_wr_idx == 2'd0)
                r_buf0 <= w_word;
            else if (w_deq)
                r_buf0 <= r_buf1;

            if (r_infl && w_wr_idx == 2'd1)
                r_buf1 <= w_word;
            else if (w_deq)
                r_buf1 <= r_buf2;

            if (r_infl && w_wr_idx == 2'd2)
                r_buf2 <= w_word;
        end
    end

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf0[EW-1:2];
    assign out_sop   = r_buf0[1];
    assign out_eop   = r_buf0[0];
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Directed bench for pkt_fifo_reader: behavioural sync FIFO in front, negedge monitor behind.
module tb_pkt_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        len_err;

    always #5 clk = ~clk;

    pkt_fifo_reader #(.DATA_WIDTH(16), .LEN_WIDTH(9), .MAX_PKT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .len_err(len_err)
    );

    // Source FIFO model, one-cycle read latency.
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush_req = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush_req)
            rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Output monitor.
    int          cyc_cnt = 0, cap_cnt = 0, pops = 0, acc = 0, max_out = 0;
    int          stable_viol = 0, pop_empty = 0, len_err_cnt = 0, len_err_wide = 0;
    logic [15:0] cap_data [0:255];
    logic        cap_sop  [0:255];
    logic        cap_eop  [0:255];
    int          cap_cyc  [0:255];
    logic        hold_prev = 1'b0, len_prev = 1'b0;
    logic [17:0] prev_out = '0;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!rst_n) begin
            pops      <= 0;
            acc       <= 0;
            hold_prev <= 1'b0;
            len_prev  <= 1'b0;
        end else begin
            if (pops - acc > max_out) max_out <= pops - acc;
            if (fifo_rd_en && fifo_empty) pop_empty <= pop_empty + 1;
            if (hold_prev && (!out_valid || {out_data, out_sop, out_eop} != prev_out))
                stable_viol <= stable_viol + 1;
            hold_prev <= out_valid && !out_ready;
            prev_out  <= {out_data, out_sop, out_eop};
            if (len_err) begin
                len_err_cnt <= len_err_cnt + 1;
                if (len_prev) len_err_wide <= len_err_wide + 1;
            end
            len_prev <= len_err;
            if (fifo_rd_en) pops <= pops + 1;
            if (out_valid && out_ready) begin
                cap_data[cap_cnt[7:0]] <= out_data;
                cap_sop[cap_cnt[7:0]]  <= out_sop;
                cap_eop[cap_cnt[7:0]]  <= out_eop;
                cap_cyc[cap_cnt[7:0]]  <= cyc_cnt;
                cap_cnt <= cap_cnt + 1;
                acc     <= acc + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(logic [15:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_caps(int target, string tag);
        int k = 0;
        while (cap_cnt < target && k < 200) begin
            cyc();
            k++;
        end
        chk({tag, "_timeout"}, 32'(cap_cnt >= target), 1);
    endtask

    task automatic chk_word(string tag, int idx, logic [15:0] d, logic s, logic e);
        chk(tag, {cap_data[idx], cap_sop[idx], cap_eop[idx]}, {d, s, e});
    endtask

    initial begin
        int          base, first_rd, first_v, base_pops, len_base;
        logic [15:0] exp_d [0:9];
        logic        exp_s [0:9];
        logic        exp_e [0:9];

        rst_n     = 1'b0;
        out_ready = 1'b1;

        // Reset with empty FIFO, then release mid-cycle.
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("reset_outputs", {out_valid, fifo_rd_en, out_sop, out_eop, len_err, out_data}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_outputs", {out_valid, fifo_rd_en, out_sop, out_eop, len_err, out_data}, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_outputs", {out_valid, fifo_rd_en, out_sop, out_eop, len_err, out_data}, 0);
        end

        // Header 3 plus three payload words: latency and back-to-back output.
        base = cap_cnt;
        push(16'h0003); push(16'h00A1); push(16'h00A2); push(16'h00A3);
        first_rd = -1;
        first_v  = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (out_valid && first_v < 0) first_v = k;
        end
        cyc();
        chk("first_pop_cycle", first_rd, 0);
        chk("pop_to_valid_latency", first_v - first_rd, 2);
        wait_caps(base + 4, "pkt3");
        chk_word("pkt3_w0", base + 0, 16'h0003, 1'b1, 1'b0);
        chk_word("pkt3_w1", base + 1, 16'h00A1, 1'b0, 1'b0);
        chk_word("pkt3_w2", base + 2, 16'h00A2, 1'b0, 1'b0);
        chk_word("pkt3_w3", base + 3, 16'h00A3, 1'b0, 1'b1);
        chk("pkt3_consecutive", cap_cyc[base + 3] - cap_cyc[base], 3);

        // Zero-length packet followed by a one-word packet.
        base = cap_cnt;
        push(16'h0000); push(16'h0001); push(16'h00B1);
        wait_caps(base + 3, "pkt0");
        chk_word("pkt0_hdr", base + 0, 16'h0000, 1'b1, 1'b1);
        chk_word("pkt1_hdr", base + 1, 16'h0001, 1'b1, 1'b0);
        chk_word("pkt1_w1",  base + 2, 16'h00B1, 1'b0, 1'b1);

        // Ten words under out_ready pattern 1,0,0,1.
        base = cap_cnt;
        exp_d = '{16'h0004, 16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4,
                  16'h0004, 16'h00D5, 16'h00D6, 16'h00D7, 16'h00D8};
        exp_s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) push(exp_d[i]);
        for (int k = 0; k < 120 && cap_cnt < base + 10; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            cyc();
        end
        out_ready = 1'b1;
        chk("bp_count", cap_cnt - base, 10);
        for (int i = 0; i < 10; i++)
            chk_word("bp_word", base + i, exp_d[i], exp_s[i], exp_e[i]);
        chk("bp_stable", stable_viol, 0);
        chk("bp_max_held", max_out, 3);

        // Full stall: exactly three pops, head held, then drain.
        out_ready = 1'b0;
        base      = cap_cnt;
        base_pops = pops;
        push(16'h0004); push(16'h00F1); push(16'h00F2); push(16'h00F3); push(16'h00F4);
        cyc(10);
        chk("stall_pops", pops - base_pops, 3);
        chk("stall_head", {out_valid, out_sop, out_eop, out_data}, {3'b110, 16'h0004});
        chk("stall_rd_en", fifo_rd_en, 0);
        out_ready = 1'b1;
        wait_caps(base + 5, "stall");
        chk_word("stall_w0", base + 0, 16'h0004, 1'b1, 1'b0);
        chk_word("stall_w4", base + 4, 16'h00F4, 1'b0, 1'b1);
        chk("stall_stable", stable_viol, 0);

        // Header N=6 against MAX_PKT_LEN=4.
        base     = cap_cnt;
        len_base = len_err_cnt;
        exp_d[0:6] = '{16'h0006, 16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4, 16'h0001, 16'h00C6};
`ifdef PKT_LEN_CHECK_EN
        exp_s[0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_e[0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_s[0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_e[0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 7; i++) push(exp_d[i]);
        wait_caps(base + 7, "len");
        cyc(3);
        for (int i = 0; i < 7; i++)
            chk_word("len_word", base + i, exp_d[i], exp_s[i], exp_e[i]);
`ifdef PKT_LEN_CHECK_EN
        chk("len_err_pulses", len_err_cnt - len_base, 1);
`else
        chk("len_err_pulses", len_err_cnt - len_base, 0);
`endif
        chk("len_err_width", len_err_wide, 0);

        // Reset after two payload words; next packet must start clean.
        base = cap_cnt;
        push(16'h0004); push(16'h00E1); push(16'h00E2); push(16'h00E3); push(16'h00E4);
        for (int k = 0; k < 50 && cap_cnt < base + 3; k++) cyc();
        chk("mid_pkt_progress", cap_cnt - base, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {out_valid, fifo_rd_en, out_sop, out_eop, len_err, out_data}, 0);
        cyc(2);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        push(16'h0001); push(16'h0091);
        cyc();
        chk("held_reset_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        base = cap_cnt;
        wait_caps(base + 2, "post_reset");
        chk_word("post_reset_hdr", base + 0, 16'h0001, 1'b1, 1'b0);
        chk_word("post_reset_w1",  base + 1, 16'h0091, 1'b0, 1'b1);

        chk("pop_while_empty", pop_empty, 0);
        chk("max_held_le3", 32'(max_out <= 3), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
